// File: rtl/array_22_pkg.sv
// rtl/array_22_pkg.sv - shared constants and state type for the array_22 controller
package array_22_pkg;

  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 96;
  localparam int MASK_W = 16;
  localparam int GRAN_W = DATA_W / MASK_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/array_22_if.sv
// rtl/array_22_if.sv - request/response handshake bundle for the array_22 controller
interface array_22_if
  import array_22_pkg::*;
#(
  parameter int ADDR_W = array_22_pkg::ADDR_W,
  parameter int DATA_W = array_22_pkg::DATA_W,
  parameter int MASK_W = array_22_pkg::MASK_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/array_22_resp_fifo.sv
// rtl/array_22_resp_fifo.sv - two-entry read response buffer
module array_22_resp_fifo #(
  parameter int W = 96
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign valid   = (count != 2'd0);
  assign data    = mem[rd_ptr];

  // Storage, pointers and occupancy; reset zeroes the storage so the head reads 0
  always_ff @(posedge clock) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/array_22_ctrl.sv
// rtl/array_22_ctrl.sv - masked single-port array controller with zero-fill and read buffering
module array_22_ctrl
  import array_22_pkg::*;
#(
  parameter int DEPTH          = array_22_pkg::DEPTH,
  parameter int ADDR_W         = array_22_pkg::ADDR_W,
  parameter int DATA_W         = array_22_pkg::DATA_W,
  parameter int MASK_W         = array_22_pkg::MASK_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  array_22_if.slave         bus,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic              s1;
  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic              pop;
  logic              credit_ok;
  logic              run;
  logic              accept;

  // State register plus clear counter and the one-cycle read-in-flight flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt <= '0;
      s1      <= 1'b0;
    end else begin
      state   <= state_nx;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
      s1      <= accept && !bus.req_write;
    end
  end

  // Leave CLEAR once the last array entry has been written
  always_comb begin
    state_nx = state;
    if ((state == CLEAR) && (clr_cnt == ADDR_W'(DEPTH - 1))) begin
      state_nx = RUN;
    end
  end

  // Handshake, read credit and array port drive; reset masks every output
  always_comb begin
    pop           = bus.resp_valid && bus.resp_ready;
    // buffered + in-flight + this read, minus the one leaving, must fit in 2
    credit_ok     = ({1'b0, fifo_count} + {2'b00, s1}) <= (3'd1 + {2'b00, pop});
    run           = (state == RUN) && !reset;
    bus.req_ready = run && (bus.req_write || credit_ok);
    accept        = bus.req_valid && bus.req_ready;
    init_done     = run;
    sram_en       = 1'b0;
    sram_wmode    = 1'b0;
    sram_addr     = '0;
    sram_wmask    = '0;
    sram_wdata    = '0;
    if (!reset && (state == CLEAR)) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = clr_cnt;
      sram_wmask = '1;
      sram_wdata = '0;
    end else if (accept) begin
      sram_en    = 1'b1;
      sram_wmode = bus.req_write;
      sram_addr  = bus.req_addr;
      sram_wmask = bus.req_wmask;
      sram_wdata = bus.req_wdata;
    end
  end

  assign bus.resp_valid = fifo_valid && !reset;

  array_22_resp_fifo #(
    .W (DATA_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (s1),
    .push_data (sram_rdata),
    .pop       (pop),
    .valid     (fifo_valid),
    .data      (bus.resp_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_array_22_ctrl.sv
// tb/tb_array_22_ctrl.sv - self-checking bench for array_22_ctrl
module tb_array_22_ctrl;
  import array_22_pkg::*;

  logic              clock;
  logic              reset;
  logic              init_done;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  array_22_if bus ();

  array_22_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual no event required event within bound", name);
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [MASK_W-1:0] m,
                                               input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r = old;
    for (int i = 0; i < MASK_W; i++)
      if (m[i]) r[i*GRAN_W +: GRAN_W] = d[i*GRAN_W +: GRAN_W];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] pat(input int i);
    logic [31:0] v = 32'h1357_0000 + 32'(i);
    return {v, ~v, v};
  endfunction

  // Array model: read-before-write, read data held until the next read
  logic [DATA_W-1:0] sram_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) sram_mem[i] = {$urandom, $urandom, $urandom};
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_wmask, sram_wdata);
      else            sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Cycles since reset release
  int   since_rst = -1;
  logic rst_q = 1'b0;
  always @(posedge clock) begin
    rst_q <= reset;
    if (reset) since_rst <= 0;
    else if (since_rst >= 0) since_rst <= since_rst + 1;
  end

  // Reference model: golden contents, expected response order, observed responses
  logic [DATA_W-1:0] gold [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] got_q [$];
  logic              hold_q = 1'b0;
  logic [DATA_W-1:0] hold_data;

  always @(negedge clock) begin : mon
    logic pop_v;
    logic acc_v;
    logic w;
    if (reset) begin
      if (rst_q) begin
        check("rst_outputs", {bus.req_ready, bus.resp_valid, init_done, sram_en}, 4'b0000);
        check("rst_resp_data", bus.resp_data, '0);
      end
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) gold[i] = '0;
      hold_q = 1'b0;
    end else if (since_rst >= 0) begin
      pop_v = bus.resp_valid && bus.resp_ready;
      acc_v = bus.req_valid && bus.req_ready;
      w     = bus.req_write;
      if (since_rst < DEPTH) begin
        check("clear_port", {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata},
              {1'b1, 1'b1, since_rst[ADDR_W-1:0], {MASK_W{1'b1}}, {DATA_W{1'b0}}});
        check("clear_status", {init_done, bus.req_ready, bus.resp_valid}, 3'b000);
      end else begin
        check("init_done", init_done, 1'b1);
        if (bus.req_valid && w) check("wr_ready", bus.req_ready, 1'b1);
        if (bus.req_valid && !w)
          check("rd_ready", bus.req_ready, (exp_q.size() + 1 - int'(pop_v)) <= 2);
        if (acc_v)
          check("acc_port", {sram_en, sram_wmode, sram_addr, w ? sram_wmask : '0, w ? sram_wdata : '0},
                {1'b1, w, bus.req_addr, w ? bus.req_wmask : '0, w ? bus.req_wdata : '0});
        else
          check("idle_en", sram_en, 1'b0);
      end
      if (hold_q) check("resp_hold", {bus.resp_valid, bus.resp_data}, {1'b1, hold_data});
      if (pop_v) begin
        if (exp_q.size() == 0) check("resp_unexpected", {1'b1, bus.resp_data}, '0);
        else check("resp_data", bus.resp_data, exp_q.pop_front());
        got_q.push_back(bus.resp_data);
      end
      if (acc_v) begin
        if (w) gold[bus.req_addr] = merge(gold[bus.req_addr], bus.req_wmask, bus.req_wdata);
        else   exp_q.push_back(gold[bus.req_addr]);
      end
      hold_q    = bus.resp_valid && !bus.resp_ready;
      hold_data = bus.resp_data;
    end
  end

  // Present one request and hold it until accepted; returns at posedge+1
  task automatic drive(input logic w, input logic [ADDR_W-1:0] a,
                       input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
    int k = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wmask = m;
    bus.req_wdata = d;
    forever begin
      @(negedge clock);
      if (bus.req_ready) break;
      k++;
      if (k > 50) begin note_timeout("drive"); break; end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_init(output int k);
    k = 0;
    forever begin
      @(negedge clock);
      if (init_done) break;
      k++;
      if (k > DEPTH + 100) begin note_timeout("wait_init"); break; end
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got_q.size() < n) begin
      @(negedge clock);
      k++;
      if (k > 60) begin note_timeout("wait_got"); break; end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int acc;
    int bad_rdy;
    logic last_rdy;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wmask  = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_sram_en", sram_en, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Zero-fill then read an untouched address
    wait_init(k);
    check("init_cycles", k, DEPTH);
    got_q.delete();
    drive(1'b0, 12'hABC, '0, '0);
    wait_got(1);
    check("read_abc", got_q[0], 96'h0);

    // Masked write merges only granule 0
    got_q.delete();
    drive(1'b1, 12'h010, 16'hFFFF, {DATA_W{1'b1}});
    drive(1'b1, 12'h010, 16'h0001, '0);
    drive(1'b0, 12'h010, '0, '0);
    wait_got(1);
    check("masked_merge", got_q[0], 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFC0);

    // Back-to-back reads at full rate
    for (int i = 0; i < 8; i++) drive(1'b1, ADDR_W'(i), 16'hFFFF, pat(i));
    n = 0;
    bad_rdy = 0;
    for (int c = 0; c < 12; c++) begin
      bus.req_valid = (c < 8);
      bus.req_write = 1'b0;
      bus.req_addr  = ADDR_W'(c);
      @(negedge clock);
      if (c < 8 && !bus.req_ready) bad_rdy++;
      if (bus.resp_valid) begin
        check("b2b_cycle", c, n + 2);
        check("b2b_data", bus.resp_data, pat(n));
        n++;
      end
      @(posedge clock); #1;
    end
    bus.req_valid = 1'b0;
    check("b2b_ready_drops", bad_rdy, 0);
    check("b2b_count", n, 8);

    // Backpressure: only two reads fit, writes still flow
    drive(1'b1, 12'h040, 16'hFFFF, 96'hA);
    drive(1'b1, 12'h041, 16'hFFFF, 96'hB);
    drive(1'b1, 12'h042, 16'hFFFF, 96'hC);
    got_q.delete();
    bus.resp_ready = 1'b0;
    acc = 0;
    last_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 12'h040 + ADDR_W'(acc);
      @(negedge clock);
      last_rdy = bus.req_ready;
      if (bus.req_ready) acc++;
      @(posedge clock); #1;
    end
    check("bp_accepted", acc, 2);
    check("bp_ready_low", last_rdy, 1'b0);
    bus.req_write = 1'b1;
    bus.req_addr  = 12'h050;
    bus.req_wmask = 16'hFFFF;
    bus.req_wdata = 96'h77;
    @(negedge clock);
    check("bp_write_ready", bus.req_ready, 1'b1);
    @(posedge clock); #1;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    drive(1'b0, 12'h042, '0, '0);
    wait_got(3);
    check("bp_order0", got_q[0], 96'hA);
    check("bp_order1", got_q[1], 96'hB);
    check("bp_order2", got_q[2], 96'hC);

    // Read followed immediately by a write to the same address
    drive(1'b1, 12'h020, 16'hFFFF, 96'h5);
    got_q.delete();
    drive(1'b0, 12'h020, '0, '0);
    drive(1'b1, 12'h020, 16'hFFFF, 96'h9);
    drive(1'b0, 12'h020, '0, '0);
    wait_got(2);
    check("raw_old", got_q[0], 96'h5);
    check("raw_new", got_q[1], 96'h9);

    // Reset in the middle of the zero-fill
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    k = 0;
    while (since_rst != 100 && k < 200) begin @(posedge clock); #1; k++; end
    @(negedge clock);
    check("clr_at_100", sram_addr, 12'd100);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    wait_init(k);
    check("reinit_cycles", k, DEPTH);

    // Reset with two responses buffered
    bus.resp_ready = 1'b0;
    drive(1'b0, 12'h040, '0, '0);
    drive(1'b0, 12'h041, '0, '0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("buffered_valid", bus.resp_valid, 1'b1);
    @(posedge clock); #1;
    got_q.delete();
    bus.resp_ready = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    wait_init(k);
    check("flush_init_cycles", k, DEPTH);
    check("flush_no_resp", got_q.size(), 0);
    drive(1'b0, 12'h040, '0, '0);
    wait_got(1);
    check("flush_cleared", got_q[0], 96'h0);

    repeat (4) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/array_22_ctrl.md
ARRAY_22_CTRL -- requirements
Module: array_22_ctrl

Interface
REQ-001 Parameter DEPTH, 4096, number of array entries.
REQ-002 Parameter ADDR_W, 12, address width (log2 DEPTH).
REQ-003 Parameter DATA_W, 96, data width.
REQ-004 Parameter MASK_W, 16, write-mask width; each mask bit covers DATA_W/MASK_W = 6 data bits.
REQ-005 Parameter CLEAR_ON_RESET, 1, enables the post-reset zero-fill of the whole array.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high; the ports SHALL be named clock and reset.
REQ-007 clock  in  1  sole clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 req_valid  in  1  request present.
REQ-010 req_ready  out  1  request accepted this cycle when req_valid is also high.
REQ-011 req_write  in  1  1 = write, 0 = read.
REQ-012 req_addr  in  ADDR_W  request address.
REQ-013 req_wmask  in  MASK_W  write mask.
REQ-014 req_wdata  in  DATA_W  write data.
REQ-015 resp_valid  out  1  read data available.
REQ-016 resp_ready  in  1  consumer takes read data.
REQ-017 resp_data  out  DATA_W  read data.
REQ-018 init_done  out  1  zero-fill complete; requests may be accepted.
REQ-019 sram_en, sram_wmode  out  1 each  array port enable and write mode.
REQ-020 sram_addr  out  ADDR_W; sram_wmask  out  MASK_W; sram_wdata  out  DATA_W: array port drive.
REQ-021 sram_rdata  in  DATA_W  array read data, valid the cycle after a read enable and held until the next read.

Function
REQ-022 The block SHALL have two states: CLEAR and RUN.
REQ-023 After reset, the block SHALL enter CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
REQ-024 In CLEAR, each cycle the block SHALL drive sram_en=1, sram_wmode=1, sram_wmask=all ones, sram_wdata=0 and sram_addr=clear counter.
REQ-025 In CLEAR, the clear counter SHALL increment from 0; after the write at DEPTH-1 the block SHALL go to RUN.
REQ-026 The CLEAR state SHALL last exactly DEPTH cycles.
REQ-027 init_done SHALL be 1 exactly when in RUN.
REQ-028 In CLEAR, req_ready SHALL be 0.
REQ-029 In RUN, a write SHALL be accepted whenever req_valid=1, with no dependence on response-path state.
REQ-030 In RUN, a read SHALL be accepted iff fifo_count + s1 + 1 - pop <= 2, where s1 = read issued last cycle and pop = resp_valid && resp_ready; req_ready may depend combinationally on resp_ready.
REQ-031 On acceptance the block SHALL drive the array port combinationally in the same cycle: sram_en=1, sram_wmode=req_write, and sram_addr/wmask/wdata from the request.
REQ-032 The block SHALL drive sram_en=0 whenever there is no acceptance and it is not in CLEAR.
REQ-033 Read data SHALL be captured from sram_rdata at the end of cycle T+1 into a 2-entry FIFO; resp_valid is asserted from T+2, a latency of 2.
REQ-034 Responses SHALL be returned in request order.
REQ-035 Read throughput SHALL sustain 1 read/cycle while resp_ready=1.
REQ-036 A read accepted at T SHALL return the array contents as of before any write accepted at T+1 or later.
REQ-037 A read accepted at T SHALL reflect every write accepted before T.
REQ-038 A simultaneous FIFO push and pop SHALL leave the FIFO count unchanged.
REQ-039 The FIFO SHALL never overflow; overflow prevention is guaranteed by the REQ-030 credit rule.
REQ-040 resp_data SHALL hold its value and resp_valid SHALL stay high while resp_ready=0.

Reset
REQ-041 While reset=1: req_ready=0, resp_valid=0, init_done=0, sram_en=0, clear counter=0, s1=0 and FIFO empty.
REQ-042 resp_data SHALL be 0 after reset.
REQ-043 Reset asserted mid-CLEAR or mid-RUN SHALL discard in-flight reads and buffered responses without emitting them.
REQ-044 Reset asserted mid-operation SHALL restart the zero-fill from address 0.

Structure
REQ-045 Package array_22_pkg SHALL hold DEPTH, ADDR_W, DATA_W, MASK_W, the 6-bit granule constant and the state enum {CLEAR, RUN}.
REQ-046 The response FIFO SHALL be a sub-module named array_22_resp_fifo with 2 entries, push/pop, count output and synchronous reset.

Verification
REQ-047 Release reset -> 4096 cycles of sram writes, addr 0..4095, wdata 0, wmask 0xFFFF; init_done rises on cycle 4096; then read 0xABC -> resp_data 0.
REQ-048 Write addr 0x010 with data all ones and mask 0xFFFF, then write data 0 with mask 0x0001, then read -> resp_data = all ones with bits [5:0] = 0.
REQ-049 Reads to addrs 0..7 back-to-back with resp_ready=1 -> req_ready never drops; 8 responses on consecutive cycles, first at accept+2, in order.
REQ-050 resp_ready=0 with 3 reads offered -> exactly 2 accepted and req_ready=0 thereafter; writes are still accepted; after resp_ready=1, data arrives in order and the third read is accepted.
REQ-051 Read 0x020 (holding 0x5) at T, then write 0x020 = 0x9 at T+1 -> response 0x5; a subsequent read -> 0x9.
REQ-052 Reset pulsed at clear counter 100, and separately with 2 responses buffered -> counter restarts at 0; no responses are emitted; init_done=0 until 4096 further cycles have elapsed.
